// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the interrupt arbiter: the arbiter FSM state
// encoding and the default bus-request (BR) priority level of each port.
// No ports; imported by intr_prio_sel and intr_arb.
// ---------------------------------------------------------------------------
package intr_pkg;

    localparam int NPORTS = 4;

    // Arbiter phases: wait for a request, present it, acknowledge it,
    // then back off before looking at requests again.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        GRANT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam logic [2:0] BR0_DEFAULT = 3'd4;
    localparam logic [2:0] BR1_DEFAULT = 3'd5;
    localparam logic [2:0] BR2_DEFAULT = 3'd6;
    localparam logic [2:0] BR3_DEFAULT = 3'd7;

endpackage

// File: rtl/intr_prio_sel.sv
// ---------------------------------------------------------------------------
// intr_prio_sel
// Combinational priority selector. A port is eligible when it requests and
// its BR level is strictly above the processor priority. The winner is the
// eligible port with the highest BR; ties resolve to the lowest index.
// Ports:
//   req      in  4  request per port
//   cpu_ipl  in  3  current processor priority
//   br0..br3 in  3  BR level of each port
//   valid    out 1  at least one port is eligible
//   index    out 2  winning port index (0 when valid=0)
// ---------------------------------------------------------------------------
module intr_prio_sel
    import intr_pkg::*;
(
    input  logic [3:0] req,
    input  logic [2:0] cpu_ipl,
    input  logic [2:0] br0,
    input  logic [2:0] br1,
    input  logic [2:0] br2,
    input  logic [2:0] br3,
    output logic       valid,
    output logic [1:0] index
);

    logic [NPORTS-1:0][2:0] brs;
    logic [2:0]             best;

    assign brs = {br3, br2, br1, br0};

    // Scan from port 0 upward and only replace the current best on a
    // strictly higher level, so equal levels keep the lower index.
    always_comb begin
        valid = 1'b0;
        index = 2'd0;
        best  = 3'd0;
        for (int n = 0; n < NPORTS; n++) begin
            if (req[n] && (brs[n] > cpu_ipl) && (!valid || (brs[n] > best))) begin
                valid = 1'b1;
                index = 2'(n);
                best  = brs[n];
            end
        end
    end

endmodule

// File: rtl/intr_arb.sv
// ---------------------------------------------------------------------------
// intr_arb
// Four-port vectored interrupt arbiter. Picks the highest-priority eligible
// device, presents its vector to the CPU, and on acknowledge pulses a
// one-hot grant back to that device, then holds off for HOLDOFF cycles.
// Ports:
//   clk           in  1   clock, all state changes on rising edge
//   reset_n       in  1   synchronous active-low reset
//   dev_req       in  4   level request per device
//   dev_vec       in  32  8-bit vector per device, port n at [8n+7:8n]
//   cpu_ipl       in  3   processor priority
//   interrupt_ack in  1   CPU accepts the presented vector
//   interrupt     out 1   registered interrupt request
//   vector        out 8   vector of the current winner, 0 when idle
//   dev_grant     out 4   one-hot one-cycle acknowledge to the winner
// ---------------------------------------------------------------------------
module intr_arb
    import intr_pkg::*;
#(
    parameter logic [2:0] BR0     = BR0_DEFAULT,
    parameter logic [2:0] BR1     = BR1_DEFAULT,
    parameter logic [2:0] BR2     = BR2_DEFAULT,
    parameter logic [2:0] BR3     = BR3_DEFAULT,
    parameter int         HOLDOFF = 2
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  dev_req,
    input  logic [31:0] dev_vec,
    input  logic [2:0]  cpu_ipl,
    input  logic        interrupt_ack,
    output logic        interrupt,
    output logic [7:0]  vector,
    output logic [3:0]  dev_grant
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    state_e     state_q;
    logic [1:0] win_idx_q;
    logic [2:0] win_br_q;
    logic [7:0] win_vec_q;
    logic [3:0] hold_cnt_q;
    logic       interrupt_q;
    logic [7:0] vector_q;
    logic [3:0] dev_grant_q;

    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [2:0] sel_br_d;
    logic [7:0] sel_vec_d;
    logic       withdrawn;

    intr_prio_sel u_sel (
        .req     (dev_req),
        .cpu_ipl (cpu_ipl),
        .br0     (BR0),
        .br1     (BR1),
        .br2     (BR2),
        .br3     (BR3),
        .valid   (sel_valid),
        .index   (sel_idx)
    );

    // BR level and vector slice of the current selector winner, latched
    // on entry to PEND so later input changes cannot alter the offer.
    always_comb begin
        sel_br_d = BR0;
        case (sel_idx)
            2'd0:    sel_br_d = BR0;
            2'd1:    sel_br_d = BR1;
            2'd2:    sel_br_d = BR2;
            default: sel_br_d = BR3;
        endcase
        sel_vec_d = dev_vec[{sel_idx, 3'b000} +: 8];
    end

    // The pending winner is dropped if it withdraws or the CPU raises its
    // priority to or above the winner's level.
    assign withdrawn = !dev_req[win_idx_q] || (cpu_ipl >= win_br_q);

    // Main FSM; all outputs are registered here. Acknowledge is checked
    // before withdrawal so a same-cycle ack always wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            win_idx_q   <= 2'd0;
            win_br_q    <= 3'd0;
            win_vec_q   <= 8'o0;
            hold_cnt_q  <= 4'd0;
            interrupt_q <= 1'b0;
            vector_q    <= 8'o0;
            dev_grant_q <= 4'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dev_grant_q <= 4'b0;
                    if (sel_valid) begin
                        win_idx_q   <= sel_idx;
                        win_br_q    <= sel_br_d;
                        win_vec_q   <= sel_vec_d;
                        interrupt_q <= 1'b1;
                        vector_q    <= sel_vec_d;
                        state_q     <= PEND;
                    end else begin
                        interrupt_q <= 1'b0;
                        vector_q    <= 8'o0;
                    end
                end
                PEND: begin
                    if (interrupt_ack) begin
                        interrupt_q <= 1'b0;
                        vector_q    <= 8'o0;
                        dev_grant_q <= 4'b0001 << win_idx_q;
                        state_q     <= GRANT;
                    end else if (withdrawn) begin
                        interrupt_q <= 1'b0;
                        vector_q    <= 8'o0;
                        state_q     <= IDLE;
                    end else begin
                        interrupt_q <= 1'b1;
                        vector_q    <= win_vec_q;
                    end
                end
                GRANT: begin
                    dev_grant_q <= 4'b0;
                    hold_cnt_q  <= 4'd0;
                    state_q     <= HOLD;
                end
                default: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_q <= 4'd0;
                        state_q    <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    assign interrupt = interrupt_q;
    assign vector    = vector_q;
    assign dev_grant = dev_grant_q;

endmodule

// File: tb/tb_intr_arb.sv
// ---------------------------------------------------------------------------
// tb_intr_arb
// Drives two arbiter instances from the same inputs: one with default
// parameters and one with equal BR levels on ports 0 and 1 (and a longer
// holdoff). A transaction-level reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares after every edge.
// ---------------------------------------------------------------------------
module tb_intr_arb;

    logic        clk = 1'b1;
    logic        reset_n;
    logic [3:0]  dev_req;
    logic [31:0] dev_vec;
    logic [2:0]  cpu_ipl;
    logic        interrupt_ack;

    logic        interrupt0, interrupt1;
    logic [7:0]  vector0, vector1;
    logic [3:0]  dev_grant0, dev_grant1;

    int vectorsApplied = 0;
    int miscompares    = 0;
    bit stimDone       = 1'b0;

    typedef struct packed {
        logic       int0;
        logic [7:0] vec0;
        logic [3:0] gnt0;
        logic       int1;
        logic [7:0] vec1;
        logic [3:0] gnt1;
    } expect_t;

    expect_t expQ[$];

    // Reference model: per instance, which phase of an interrupt
    // transaction it is in and what the offered transaction is.
    int         brTab[2][4] = '{'{4, 5, 6, 7}, '{5, 5, 6, 7}};
    int         holdTab[2]  = '{2, 3};
    int         mPhase[2];     // 0 waiting, 1 offered, 2 granted, 3 backing off
    int         mPort[2];
    int         mLevel[2];
    logic [7:0] mVec[2];
    int         mWait[2];

    always #5 clk = ~clk;

    intr_arb u_def (
        .clk           (clk),
        .reset_n       (reset_n),
        .dev_req       (dev_req),
        .dev_vec       (dev_vec),
        .cpu_ipl       (cpu_ipl),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt0),
        .vector        (vector0),
        .dev_grant     (dev_grant0)
    );

    intr_arb #(.BR0(3'd5), .BR1(3'd5), .HOLDOFF(3)) u_eq (
        .clk           (clk),
        .reset_n       (reset_n),
        .dev_req       (dev_req),
        .dev_vec       (dev_vec),
        .cpu_ipl       (cpu_ipl),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt1),
        .vector        (vector1),
        .dev_grant     (dev_grant1)
    );

    // Predict what instance k shows after the next rising edge.
    task automatic modelStep(input int k, output logic oInt, output logic [7:0] oVec,
                             output logic [3:0] oGnt);
        int best;
        oInt = 1'b0;
        oVec = 8'o0;
        oGnt = 4'b0;
        if (!reset_n) begin
            mPhase[k] = 0; mPort[k] = 0; mLevel[k] = 0; mVec[k] = 8'o0; mWait[k] = 0;
            return;
        end
        case (mPhase[k])
            0: begin
                best = -1;
                for (int n = 0; n < 4; n++)
                    if (dev_req[n] && brTab[k][n] > int'(cpu_ipl) &&
                        (best < 0 || brTab[k][n] > brTab[k][best]))
                        best = n;
                if (best >= 0) begin
                    mPhase[k] = 1;
                    mPort[k]  = best;
                    mLevel[k] = brTab[k][best];
                    mVec[k]   = dev_vec[best*8 +: 8];
                    oInt = 1'b1;
                    oVec = mVec[k];
                end
            end
            1: begin
                if (interrupt_ack) begin
                    mPhase[k] = 2;
                    oGnt[mPort[k]] = 1'b1;
                end else if (!dev_req[mPort[k]] || int'(cpu_ipl) >= mLevel[k]) begin
                    mPhase[k] = 0;
                end else begin
                    oInt = 1'b1;
                    oVec = mVec[k];
                end
            end
            2: begin
                mPhase[k] = 3;
                mWait[k]  = holdTab[k];
            end
            default: begin
                mWait[k]--;
                if (mWait[k] == 0) mPhase[k] = 0;
            end
        endcase
    endtask

    // Drive one cycle of inputs on the falling edge and queue the
    // prediction for the following rising edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] req,
                                 input logic [31:0] vecs, input logic [2:0] ipl,
                                 input logic ack);
        expect_t e;
        @(negedge clk);
        reset_n       = rst;
        dev_req       = req;
        dev_vec       = vecs;
        cpu_ipl       = ipl;
        interrupt_ack = ack;
        modelStep(0, e.int0, e.vec0, e.gnt0);
        modelStep(1, e.int1, e.vec1, e.gnt1);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Monitor: after each rising edge compare everything both DUTs present.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                vectorsApplied++;
                checkOutput("interrupt_def", {7'd0, interrupt0}, {7'd0, e.int0});
                checkOutput("vector_def",    vector0,            e.vec0);
                checkOutput("grant_def",     {4'd0, dev_grant0}, {4'd0, e.gnt0});
                checkOutput("interrupt_eq",  {7'd0, interrupt1}, {7'd0, e.int1});
                checkOutput("vector_eq",     vector1,            e.vec1);
                checkOutput("grant_eq",      {4'd0, dev_grant1}, {4'd0, e.gnt1});
            end
        end
    end

    localparam logic [31:0] VECS = {8'o74, 8'o70, 8'o64, 8'o60};

    initial begin
        logic [3:0] rReq;
        logic [2:0] rIpl;
        $display("[TB] tb_intr_arb start");
        reset_n = 1'b0; dev_req = 4'b0; dev_vec = '0; cpu_ipl = 3'd0; interrupt_ack = 1'b0;

        // Reset, then single request on port 0 with ack and holdoff.
        applyStimulus(1'b0, 4'b0000, VECS, 3'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0001, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0001, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, VECS, 3'd0, 1'b1);
        repeat (5) applyStimulus(1'b1, 4'b0000, VECS, 3'd0, 1'b0);

        // Port 1 beats port 0; drop port 1 during holdoff, port 0 follows.
        applyStimulus(1'b1, 4'b0011, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0011, VECS, 3'd0, 1'b1);
        applyStimulus(1'b1, 4'b0001, VECS, 3'd0, 1'b0);
        repeat (4) applyStimulus(1'b1, 4'b0001, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0001, VECS, 3'd0, 1'b1);
        repeat (5) applyStimulus(1'b1, 4'b0000, VECS, 3'd0, 1'b0);

        // Masking by processor priority 6, then 7.
        repeat (2) applyStimulus(1'b1, 4'b1111, VECS, 3'd6, 1'b0);
        applyStimulus(1'b1, 4'b1111, VECS, 3'd6, 1'b1);
        repeat (5) applyStimulus(1'b1, 4'b1111, VECS, 3'd7, 1'b0);

        // Cancel by raising priority; then ack with same-cycle withdrawal.
        applyStimulus(1'b1, 4'b0100, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0100, VECS, 3'd7, 1'b0);
        repeat (2) applyStimulus(1'b1, 4'b0000, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0100, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, VECS, 3'd7, 1'b1);
        repeat (5) applyStimulus(1'b1, 4'b0000, VECS, 3'd0, 1'b0);

        // Reset while pending, and reset while granting.
        applyStimulus(1'b1, 4'b1000, VECS, 3'd0, 1'b0);
        applyStimulus(1'b0, 4'b1000, VECS, 3'd0, 1'b1);
        applyStimulus(1'b1, 4'b1000, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b1000, VECS, 3'd0, 1'b1);
        applyStimulus(1'b0, 4'b1000, VECS, 3'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, VECS, 3'd0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) != 0) begin
                rReq = 4'($urandom);
                rIpl = 3'($urandom_range(7));
            end
            applyStimulus($urandom_range(60) != 0, rReq,
                          $urandom, rIpl, $urandom_range(2) == 0);
        end

        stimDone = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/intr_arb.md
INTR_ARB -- requirements
Module: intr_arb

Interface
REQ-001 Parameter BR0, default 3'd4, bus-request priority level of port 0.
REQ-002 Parameter BR1, default 3'd5, priority level of port 1.
REQ-003 Parameter BR2, default 3'd6, priority level of port 2.
REQ-004 Parameter BR3, default 3'd7, priority level of port 3.
REQ-005 Parameter HOLDOFF, default 2, cycles held after a grant before re-arbitration (range 1..15).
REQ-006 Port clk  in  1  single clock; all state SHALL change only on its rising edge.
REQ-007 Port reset_n  in  1  synchronous, active-low reset.
REQ-008 Port dev_req  in  4  level interrupt request from each device port.
REQ-009 Port dev_vec  in  32  8-bit vector per port; port n occupies bits [8n+7:8n].
REQ-010 Port cpu_ipl  in  3  current processor priority from PSW.
REQ-011 Port interrupt_ack  in  1  one-cycle CPU acceptance of the presented vector.
REQ-012 Port interrupt  out  1  registered interrupt request to CPU.
REQ-013 Port vector  out  8  latched vector of current winner; 8'o0 when interrupt=0.
REQ-014 Port dev_grant  out  4  one-hot, one-cycle acknowledge to the winning device.

Function
REQ-015 FSM states SHALL be IDLE, PEND, GRANT and HOLD.
REQ-016 Eligible port: dev_req[n]=1 and BRn > cpu_ipl (strictly greater).
REQ-017 Winner: highest BR among eligible ports; ties go to the lowest port index.
REQ-018 IDLE: if any port is eligible, latch winner index, its BR and dev_vec slice, then enter PEND (interrupt high one cycle after eligibility).
REQ-019 PEND: interrupt=1 and vector holds the latched value, stable until state exits.
REQ-020 PEND with interrupt_ack=1: enter GRANT; interrupt_ack SHALL take precedence over any same-cycle withdrawal or cpu_ipl change.
REQ-021 PEND without ack, with the winner's dev_req dropped or cpu_ipl >= latched BR: cancel and return to IDLE with interrupt=0 the next cycle.
REQ-022 PEND SHALL NOT pre-empt the winner for a newly asserted higher-priority request; re-arbitration happens only in IDLE.
REQ-023 GRANT lasts exactly one cycle: dev_grant[winner]=1, interrupt=0, then enter HOLD.
REQ-024 HOLD: a 4-bit counter runs HOLDOFF cycles with interrupt=0, then enters IDLE.
REQ-025 interrupt_ack outside PEND SHALL be ignored.
REQ-026 dev_grant SHALL be 4'b0 in every state except GRANT.
REQ-027 Latency: eligibility in IDLE to interrupt=1 is one cycle; ack to dev_grant pulse is one cycle.

Reset
REQ-028 With reset_n=0 at a clock edge: state=IDLE, interrupt=0, vector=8'o0, dev_grant=4'b0, latched index/BR/vector=0, hold counter=0.
REQ-029 Reset asserted in any state, including PEND or GRANT, SHALL take effect at that edge with no grant pulse emitted.
REQ-030 First arbitration SHALL occur in the cycle after reset_n returns to 1.

Structure
REQ-031 State encodings and default BR levels SHALL live in the shared package intr_pkg.
REQ-032 The combinational priority selector SHALL be a sub-module intr_prio_sel (inputs req, cpu_ipl, BR levels; outputs valid, index).

Verification
REQ-033 Single request: dev_req=4'b0001, dev_vec[7:0]=8'o60, cpu_ipl=0 -> interrupt=1 with vector=8'o60 next cycle; ack -> dev_grant=4'b0001 for one cycle, then HOLDOFF idle cycles.
REQ-034 Priority: dev_req=4'b0011, vectors 8'o60/8'o64, cpu_ipl=0 -> vector=8'o64 (BR5) wins; after grant, HOLD and deasserting port 1 -> 8'o60 presented.
REQ-035 Masking: dev_req=4'b1111, cpu_ipl=6 -> only port 3 presented; cpu_ipl=7 -> interrupt stays 0.
REQ-036 Cancel: in PEND raise cpu_ipl to 7 -> interrupt=0 next cycle, no dev_grant; same-cycle ack and withdrawal -> grant issued.
REQ-037 Reset in PEND: drive reset_n=0 -> interrupt=0, vector=8'o0, dev_grant=0 at that edge.
REQ-038 Equal BR: BR0=BR1=5, dev_req=4'b0011 -> port 0 wins.
